// File: rtl/alu_mc_core.sv
// Multi-cycle ALU core with a valid/ready request side and a valid/ready
// response side. Simple operations complete in one cycle. MUL, DIVU and REMU
// with a non-zero divisor iterate one bit per cycle for WIDTH cycles.
module alu_mc_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_negative,
    output logic             out_div_by_zero
);
    localparam int SH_W = $clog2(WIDTH);
    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(WIDTH - 1);
    localparam logic [SH_W-1:0] CNT_ONE  = SH_W'(1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;
    localparam logic [3:0] OP_REMU = 4'd13;
    localparam logic [3:0] OP_PA   = 4'd14;
    localparam logic [3:0] OP_PB   = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [3:0]        op_r;
    logic [WIDTH-1:0]  acc_r, x_r, y_r;
    logic [SH_W-1:0]   cnt_r;

    logic              accept_s, multi_s, last_iter_s;
    logic [WIDTH:0]    sum_s;
    logic [WIDTH-1:0]  sub_s;
    logic [SH_W-1:0]   shamt_s;
    logic [WIDTH-1:0]  res_s;
    logic              carry_s, ovf_s, dbz_s;
    logic [WIDTH:0]    rem_shift_s, diff_s;
    logic [WIDTH-1:0]  acc_nxt_s, x_nxt_s, y_nxt_s, mc_res_s;

    assign in_ready    = (state_r == IDLE) && !rst;
    assign out_valid   = (state_r == DONE);
    assign accept_s    = in_valid && in_ready;
    assign last_iter_s = (state_r == BUSY) && (cnt_r == CNT_LAST);
    assign sum_s       = {1'b0, in_a} + {1'b0, in_b};
    assign sub_s       = in_a - in_b;
    assign shamt_s     = in_b[SH_W-1:0];
    // A zero divisor short-circuits DIVU/REMU into the single-cycle path.
    assign multi_s     = (in_opcode == OP_MUL) ||
                         (((in_opcode == OP_DIVU) || (in_opcode == OP_REMU)) &&
                          (in_b != {WIDTH{1'b0}}));

    // Single-cycle result and flags straight from the request inputs.
    always_comb begin
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        dbz_s   = 1'b0;
        case (in_opcode)
            OP_ADD: begin
                res_s   = sum_s[WIDTH-1:0];
                carry_s = sum_s[WIDTH];
                ovf_s   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_s[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                res_s   = sub_s;
                carry_s = (in_a < in_b);
                ovf_s   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sub_s[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND:  res_s = in_a & in_b;
            OP_OR:   res_s = in_a | in_b;
            OP_XOR:  res_s = in_a ^ in_b;
            OP_NOT:  res_s = ~in_a;
            OP_SLL:  res_s = in_a << shamt_s;
            OP_SRL:  res_s = in_a >> shamt_s;
            OP_SRA:  res_s = $signed(in_a) >>> shamt_s;
            OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            OP_DIVU: begin
                res_s = {WIDTH{1'b1}};
                dbz_s = 1'b1;
            end
            OP_REMU: begin
                res_s = in_a;
                dbz_s = 1'b1;
            end
            OP_PA:   res_s = in_a;
            OP_PB:   res_s = in_b;
            default: res_s = {WIDTH{1'b0}};
        endcase
    end

    // One iteration of shift-add multiply or restoring shift-subtract divide.
    always_comb begin
        rem_shift_s = {acc_r, x_r[WIDTH-1]};
        diff_s      = rem_shift_s - {1'b0, y_r};
        acc_nxt_s   = acc_r;
        x_nxt_s     = x_r;
        y_nxt_s     = y_r;
        if (op_r == OP_MUL) begin
            acc_nxt_s = acc_r + (y_r[0] ? x_r : {WIDTH{1'b0}});
            x_nxt_s   = {x_r[WIDTH-2:0], 1'b0};
            y_nxt_s   = {1'b0, y_r[WIDTH-1:1]};
        end else if (!diff_s[WIDTH]) begin
            acc_nxt_s = diff_s[WIDTH-1:0];
            x_nxt_s   = {x_r[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt_s = rem_shift_s[WIDTH-1:0];
            x_nxt_s   = {x_r[WIDTH-2:0], 1'b0};
        end
        mc_res_s = (op_r == OP_DIVU) ? x_nxt_s : acc_nxt_s;
    end

    // Next-state logic for the IDLE/BUSY/DONE handshake controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = multi_s ? BUSY : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (last_iter_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture at accept and per-cycle iteration while BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r  <= 4'd0;
            acc_r <= {WIDTH{1'b0}};
            x_r   <= {WIDTH{1'b0}};
            y_r   <= {WIDTH{1'b0}};
            cnt_r <= {SH_W{1'b0}};
        end else if (accept_s) begin
            op_r  <= in_opcode;
            acc_r <= {WIDTH{1'b0}};
            x_r   <= in_a;
            y_r   <= in_b;
            cnt_r <= {SH_W{1'b0}};
        end else if (state_r == BUSY) begin
            acc_r <= acc_nxt_s;
            x_r   <= x_nxt_s;
            y_r   <= y_nxt_s;
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Response registers: loaded only on the transition into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result      <= {WIDTH{1'b0}};
            out_zero        <= 1'b0;
            out_carry       <= 1'b0;
            out_overflow    <= 1'b0;
            out_negative    <= 1'b0;
            out_div_by_zero <= 1'b0;
        end else if (accept_s && !multi_s) begin
            out_result      <= res_s;
            out_zero        <= (res_s == {WIDTH{1'b0}});
            out_carry       <= carry_s;
            out_overflow    <= ovf_s;
            out_negative    <= res_s[WIDTH-1];
            out_div_by_zero <= dbz_s;
        end else if (last_iter_s) begin
            out_result      <= mc_res_s;
            out_zero        <= (mc_res_s == {WIDTH{1'b0}});
            out_carry       <= 1'b0;
            out_overflow    <= 1'b0;
            out_negative    <= mc_res_s[WIDTH-1];
            out_div_by_zero <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_mc_core.sv
// Scoreboard bench for alu_mc_core: the driver pushes hand-computed
// expectations, a negedge monitor pops and compares each response.
module tb_alu_mc_core;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic [3:0]   in_opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_zero, out_carry, out_overflow, out_negative, out_div_by_zero;

    alu_mc_core #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result),
        .out_zero(out_zero), .out_carry(out_carry), .out_overflow(out_overflow),
        .out_negative(out_negative), .out_div_by_zero(out_div_by_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [4:0]  flags;   // {zero, carry, overflow, negative, div_by_zero}
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    bit   taken = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: compare each newly presented response with the queue head.
    always @(negedge clk) begin
        if (rst) begin
            taken = 1'b0;
        end else if (out_valid && !taken) begin
            exp_t e;
            taken = 1'b1;
            if (q.size() == 0) begin
                check("unexpected_response", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                check({e.name, "_result"}, 64'(out_result), 64'(e.res));
                check({e.name, "_flags"},
                      64'({out_zero, out_carry, out_overflow, out_negative, out_div_by_zero}),
                      64'(e.flags));
                check({e.name, "_latency"}, 64'(cyc - e.acc), 64'(e.lat));
            end
        end else if (!out_valid) begin
            taken = 1'b0;
        end
    end

    // Drive one request; caller is at a negedge with the core idle.
    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic [4:0] fl,
                         input int lat, input bit push);
        exp_t e;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_opcode = op;
        e = '{name, res, fl, lat, cyc};
        if (push) q.push_back(e);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_a      = $urandom;
        in_b      = $urandom;
        in_opcode = 4'($urandom);
    endtask

    // Wait (bounded) until the response is consumed and the core is idle.
    task automatic wait_done(input string name);
        int n;
        bit ready_seen;
        n = 0;
        ready_seen = 1'b0;
        do begin
            @(negedge clk);
            if (q.size() != 0 && in_ready) ready_seen = 1'b1;
            n++;
        end while (!(q.size() == 0 && in_ready) && n < 200);
        check({name, "_timeout"}, 64'(n < 200), 64'd1);
        check({name, "_ready_low_while_pending"}, 64'(ready_seen), 64'd0);
    endtask

    task automatic run(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic [4:0] fl,
                       input int lat);
        issue(name, op, a, b, res, fl, lat, 1'b1);
        wait_done(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_a = 32'h1; in_b = 32'h2; in_opcode = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_result", 64'(out_result), 64'd0);
        check("reset_flags",
              64'({out_zero, out_carry, out_overflow, out_negative, out_div_by_zero}), 64'd0);

        // First accept on the first edge after release.
        rst = 1'b0;
        issue("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b11000, 1, 1'b1);
        wait_done("add_wrap");

        run("add_ovf",   4'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 5'b00110, 1);
        run("sub_borrow",4'd1,  32'h0,         32'h1,         32'hFFFF_FFFF, 5'b01010, 1);
        run("sub_eq",    4'd1,  32'h5,         32'h5,         32'h0,         5'b10000, 1);
        run("sub_ovf",   4'd1,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 5'b00100, 1);
        run("and",       4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 5'b00010, 1);
        run("or",        4'd3,  32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 5'b00000, 1);
        run("xor",       4'd4,  32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0,         5'b10000, 1);
        run("not",       4'd5,  32'h0,         32'h1234_5678, 32'hFFFF_FFFF, 5'b00010, 1);
        run("sll31",     4'd6,  32'h1,         32'd31,        32'h8000_0000, 5'b00010, 1);
        run("sll_mask",  4'd6,  32'h1,         32'h21,        32'h2,         5'b00000, 1);
        run("srl",       4'd7,  32'h8000_0000, 32'd4,         32'h0800_0000, 5'b00000, 1);
        run("sra",       4'd8,  32'h8000_0000, 32'd4,         32'hF800_0000, 5'b00010, 1);
        run("slt",       4'd9,  32'hFFFF_FFFF, 32'h1,         32'h1,         5'b00000, 1);
        run("sltu",      4'd10, 32'hFFFF_FFFF, 32'h1,         32'h0,         5'b10000, 1);
        run("pass_a",    4'd14, 32'h1234_5678, 32'h0,         32'h1234_5678, 5'b00000, 1);
        run("pass_b",    4'd15, 32'hDEAD_BEEF, 32'h0,         32'h0,         5'b10000, 1);
        run("divu",      4'd12, 32'd100,       32'd7,         32'd14,        5'b00000, 33);
        run("remu",      4'd13, 32'd100,       32'd7,         32'd2,         5'b00000, 33);
        run("divu_max",  4'd12, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 5'b00010, 33);
        run("remu_small",4'd13, 32'd7,         32'd100,       32'd7,         5'b00000, 33);
        run("divu_by0",  4'd12, 32'h1234,      32'h0,         32'hFFFF_FFFF, 5'b00011, 1);
        run("remu_by0",  4'd13, 32'h1234,      32'h0,         32'h1234,      5'b00001, 1);
        run("mul",       4'd11, 32'd12345,     32'd678,       32'd8369910,   5'b00000, 33);
        run("mul_zero",  4'd11, 32'h0,         32'd5,         32'h0,         5'b10000, 33);

        // Back-pressure: hold out_ready low for 5 cycles.
        out_ready = 1'b0;
        issue("mul_hold", 4'd11, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 5'b00010, 33, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mul_hold_timeout", 64'(n < 100), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_out_result", 64'(out_result), 64'hFFFF_FFFF);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", 64'(out_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);

        // Reset in the middle of a MUL discards it.
        issue("mul_abort", 4'd11, 32'd3, 32'd5, 32'd15, 5'b00000, 33, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        check("abort_out_result", 64'(out_result), 64'd0);
        check("abort_flags",
              64'({out_zero, out_carry, out_overflow, out_negative, out_div_by_zero}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("post_abort_in_ready", 64'(in_ready), 64'd1);
        run("add_after_rst", 4'd0, 32'd2, 32'd3, 32'd5, 5'b00000, 1);

        repeat (5) @(negedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
